accessor: RTL and testbench

//  Memory-access stage; sits directly downstream of the executor and upstream of writeback.

---
 rtl/accessor.sv | 170 +++++++++++++++++
 tb/tb_accessor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accessor.sv
// Memory-access stage between executor and writeback: one bus transaction per load/store,
// ALU/LUI pass-through. Define ACCESSOR_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module accessor #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                executor_valid,
    output logic                accessor_ready,
    output logic                accessor_valid,
    input  logic                writeback_ready,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic [XLEN-1:0]     in_rd_data,
    input  logic [XLEN-1:0]     fwd_mem_addr,
    input  logic [XLEN-1:0]     fwd_mem_data,
    input  logic                fwd_is_lui,
    input  logic                fwd_is_lb,
    input  logic                fwd_is_lbu,
    input  logic                fwd_is_lh,
    input  logic                fwd_is_lhu,
    input  logic                fwd_is_lw,
    input  logic                fwd_is_sb,
    input  logic                fwd_is_sh,
    input  logic                fwd_is_sw,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [REG_BITS-1:0] out_rd,
`ifdef ACCESSOR_MISALIGN_TRAP_EN
    output logic                misaligned,
`endif
    output logic [XLEN-1:0]     out_rd_data
);

    typedef enum logic [1:0] {IDLE, MEM, HOLD} state_t;

    state_t              state_q, state_d;
    logic [REG_BITS-1:0] rd_q, rd_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [1:0]          lane_q, lane_d;
    logic                ld_byte_q, ld_byte_d;
    logic                ld_half_q, ld_half_d;
    logic                ld_sext_q, ld_sext_d;

    logic                is_load, is_store, mis;
    logic [4:0]          shamt;
    logic [XLEN-1:0]     shifted, load_val;

    assign is_load  = fwd_is_lb | fwd_is_lbu | fwd_is_lh | fwd_is_lhu | fwd_is_lw;
    assign is_store = fwd_is_sb | fwd_is_sh | fwd_is_sw;

`ifdef ACCESSOR_MISALIGN_TRAP_EN
    assign mis = ((fwd_is_lh | fwd_is_lhu | fwd_is_sh) & fwd_mem_addr[0]) |
                 ((fwd_is_lw | fwd_is_sw) & (|fwd_mem_addr[1:0]));
`else
    assign mis = 1'b0;
`endif

    // Lane extraction; without the trap, low bits below the access size are ignored.
    assign shamt    = ld_byte_q ? {lane_q, 3'b000} : (ld_half_q ? {lane_q[1], 4'b0000} : 5'd0);
    assign shifted  = mem_rdata >> shamt;
    always_comb begin
        load_val = shifted;
        if (ld_byte_q)
            load_val = {{24{ld_sext_q & shifted[7]}}, shifted[7:0]};
        else if (ld_half_q)
            load_val = {{16{ld_sext_q & shifted[15]}}, shifted[15:0]};
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        data_d    = data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        lane_d    = lane_q;
        ld_byte_d = ld_byte_q;
        ld_half_d = ld_half_q;
        ld_sext_d = ld_sext_q;
        case (state_q)
            IDLE: if (executor_valid) begin
                rd_d      = (is_store | mis) ? '0 : in_rd;
                data_d    = fwd_is_lui ? fwd_mem_addr : in_rd_data;
                addr_d    = {fwd_mem_addr[XLEN-1:2], 2'b00};
                lane_d    = fwd_mem_addr[1:0];
                ld_byte_d = fwd_is_lb | fwd_is_lbu;
                ld_half_d = fwd_is_lh | fwd_is_lhu;
                ld_sext_d = fwd_is_lb | fwd_is_lh;
                wstrb_d   = 4'b0000;
                wdata_d   = '0;
                if (fwd_is_sb) begin
                    wstrb_d = 4'b0001 << fwd_mem_addr[1:0];
                    wdata_d = {4{fwd_mem_data[7:0]}};
                end else if (fwd_is_sh) begin
                    wstrb_d = fwd_mem_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{fwd_mem_data[15:0]}};
                end else if (fwd_is_sw) begin
                    wstrb_d = 4'b1111;
                    wdata_d = fwd_mem_data;
                end
                state_d = ((is_load | is_store) & ~mis) ? MEM : HOLD;
            end
            MEM: if (mem_ready) begin
                if (!(|wstrb_q)) data_d = load_val;
                state_d = HOLD;
            end
            HOLD: if (writeback_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            data_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            lane_q    <= '0;
            ld_byte_q <= 1'b0;
            ld_half_q <= 1'b0;
            ld_sext_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            lane_q    <= lane_d;
            ld_byte_q <= ld_byte_d;
            ld_half_q <= ld_half_d;
            ld_sext_q <= ld_sext_d;
        end
    end

`ifdef ACCESSOR_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    always_comb begin
        mis_d = mis_q;
        if (state_q == IDLE && executor_valid) mis_d = mis;
        else if (state_q == HOLD && writeback_ready) mis_d = 1'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end
    assign misaligned = mis_q;
`endif

    // Handshake outputs decode the state register so reset clears them without a clock.
    assign accessor_ready = (state_q == IDLE);
    assign accessor_valid = (state_q == HOLD);
    assign mem_valid      = (state_q == MEM);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;
    assign out_rd         = rd_q;
    assign out_rd_data    = data_q;

endmodule

// File: tb/tb_accessor.sv
// Self-checking bench for accessor: directed vector table, hand-written reset/backpressure
// sequences and randomized ops checked against an arithmetic reference model.
module tb_accessor;

    typedef enum int {ALU, LUI, LB, LBU, LH, LHU, LW, SB, SH, SW} op_e;
    typedef struct {
        op_e         op;
        logic [4:0]  rd;
        logic [31:0] rdd, addr, data, rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_mis;
    } vec_t;

    logic        clk = 0, reset = 1;
    logic        executor_valid = 0, writeback_ready = 0, mem_ready = 0;
    logic        accessor_ready, accessor_valid, mem_valid;
    logic [4:0]  in_rd = 0, out_rd;
    logic [31:0] in_rd_data = 0, fwd_mem_addr = 0, fwd_mem_data = 0, mem_rdata = 0;
    logic [31:0] mem_addr, mem_wdata, out_rd_data;
    logic [3:0]  mem_wstrb;
    logic        is_lui = 0, is_lb = 0, is_lbu = 0, is_lh = 0, is_lhu = 0, is_lw = 0;
    logic        is_sb = 0, is_sh = 0, is_sw = 0;
    logic        mis_o;
    int          passed = 0, total = 0;

    accessor dut (
        .clk(clk), .reset(reset),
        .executor_valid(executor_valid), .accessor_ready(accessor_ready),
        .accessor_valid(accessor_valid), .writeback_ready(writeback_ready),
        .in_rd(in_rd), .in_rd_data(in_rd_data),
        .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
        .fwd_is_lui(is_lui), .fwd_is_lb(is_lb), .fwd_is_lbu(is_lbu),
        .fwd_is_lh(is_lh), .fwd_is_lhu(is_lhu), .fwd_is_lw(is_lw),
        .fwd_is_sb(is_sb), .fwd_is_sh(is_sh), .fwd_is_sw(is_sw),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .out_rd(out_rd),
`ifdef ACCESSOR_MISALIGN_TRAP_EN
        .misaligned(mis_o),
`endif
        .out_rd_data(out_rd_data)
    );
`ifndef ACCESSOR_MISALIGN_TRAP_EN
    assign mis_o = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic is_store(op_e op);
        return op == SB || op == SH || op == SW;
    endfunction

    // Reference model from the access rules, using plain arithmetic on the address.
    function automatic vec_t model(vec_t v);
        logic [31:0] b, h;
        logic        trap;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        v.e_mis   = trap && ((((v.op == LH) || (v.op == LHU) || (v.op == SH)) && (v.addr % 2 != 0)) ||
                             (((v.op == LW) || (v.op == SW)) && (v.addr % 4 != 0)));
        v.e_addr  = v.addr - (v.addr % 4);
        v.e_strb  = 0;
        v.e_wdata = 0;
        v.e_rd    = (is_store(v.op) || v.e_mis) ? 5'd0 : v.rd;
        b = (v.rdata >> (8 * (v.addr % 4))) & 32'hFF;
        h = (v.rdata >> (16 * ((v.addr / 2) % 2))) & 32'hFFFF;
        case (v.op)
            ALU: v.e_data = v.rdd;
            LUI: v.e_data = v.addr;
            LB:  v.e_data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LBU: v.e_data = b;
            LH:  v.e_data = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LHU: v.e_data = h;
            LW:  v.e_data = v.rdata;
            SB: begin v.e_strb = 4'(1 << (v.addr % 4)); v.e_wdata = (v.data & 32'hFF) * 32'h0101_0101; end
            SH: begin v.e_strb = ((v.addr / 2) % 2 != 0) ? 4'hC : 4'h3; v.e_wdata = (v.data & 32'hFFFF) * 32'h0001_0001; end
            SW: begin v.e_strb = 4'hF; v.e_wdata = v.data; end
            default: v.e_data = 0;
        endcase
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_rd = v.rd; in_rd_data = v.rdd; fwd_mem_addr = v.addr; fwd_mem_data = v.data;
        is_lui = (v.op == LUI); is_lb = (v.op == LB); is_lbu = (v.op == LBU);
        is_lh = (v.op == LH); is_lhu = (v.op == LHU); is_lw = (v.op == LW);
        is_sb = (v.op == SB); is_sh = (v.op == SH); is_sw = (v.op == SW);
    endtask

    // Junk on the upstream and bus inputs while busy; the stage must ignore it.
    task automatic junk(input logic with_mem_ready);
        executor_valid = 1; in_rd = 5'($urandom); in_rd_data = $urandom;
        fwd_mem_addr = $urandom; fwd_mem_data = $urandom;
        mem_ready = with_mem_ready; mem_rdata = $urandom;
    endtask

    // Runs one op; called and compared at negedges, away from the active edge.
    task automatic run(input vec_t v, input int mlat, input int wlat);
        chk("ready_idle", 32'(accessor_ready), 32'd1);
        drive(v);
        executor_valid = 1;
        @(negedge clk);
        executor_valid = 0;
        if (v.op >= LB && !v.e_mis) begin
            for (int k = 0; k <= mlat; k++) begin
                chk("mem_valid", 32'(mem_valid), 32'd1);
                chk("ready_mem", 32'(accessor_ready), 32'd0);
                chk("valid_mem", 32'(accessor_valid), 32'd0);
                chk("mem_addr", mem_addr, v.e_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(v.e_strb));
                if (is_store(v.op)) chk("mem_wdata", mem_wdata, v.e_wdata);
                if (k < mlat) begin junk(1'b0); @(negedge clk); end
            end
            mem_ready = 1; mem_rdata = v.rdata;
            @(negedge clk);
            mem_ready = 0; mem_rdata = $urandom;
        end
        for (int k = 0; k <= wlat; k++) begin
            chk("acc_valid", 32'(accessor_valid), 32'd1);
            chk("ready_hold", 32'(accessor_ready), 32'd0);
            chk("mem_valid_hold", 32'(mem_valid), 32'd0);
            chk("out_rd", 32'(out_rd), 32'(v.e_rd));
            if (!is_store(v.op) && !v.e_mis) chk("out_rd_data", out_rd_data, v.e_data);
`ifdef ACCESSOR_MISALIGN_TRAP_EN
            chk("misaligned", 32'(mis_o), 32'(v.e_mis));
`endif
            if (k < wlat) begin junk(1'b1); @(negedge clk); end
        end
        writeback_ready = 1; executor_valid = 0; mem_ready = 0;
        @(negedge clk);
        writeback_ready = 0;
        chk("valid_after_wb", 32'(accessor_valid), 32'd0);
        chk("ready_after_wb", 32'(accessor_ready), 32'd1);
    endtask

    function automatic vec_t mk(op_e op, logic [4:0] rd, logic [31:0] rdd, logic [31:0] addr,
                                logic [31:0] data, logic [31:0] rdata, logic [31:0] e_addr,
                                logic [3:0] e_strb, logic [31:0] e_wdata, logic [4:0] e_rd,
                                logic [31:0] e_data, logic e_mis);
        vec_t v;
        v.op = op; v.rd = rd; v.rdd = rdd; v.addr = addr; v.data = data; v.rdata = rdata;
        v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_rd = e_rd;
        v.e_data = e_data; v.e_mis = e_mis;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t v;

        tbl.push_back(mk(ALU, 5, 32'h1234, 0, 0, 0, 0, 4'h0, 0, 5, 32'h1234, 0));
        tbl.push_back(mk(LB, 7, 0, 32'h103, 0, 32'h80FF_FF11, 32'h100, 4'h0, 0, 7, 32'hFFFF_FF80, 0));
        tbl.push_back(mk(LBU, 8, 0, 32'h103, 0, 32'h80FF_FF11, 32'h100, 4'h0, 0, 8, 32'h0000_0080, 0));
        tbl.push_back(mk(SH, 9, 0, 32'h202, 32'hABCD_BEEF, 0, 32'h200, 4'hC, 32'hBEEF_BEEF, 0, 0, 0));
        tbl.push_back(mk(LUI, 3, 32'h5555, 32'h1234_5000, 0, 0, 32'h1234_5000, 4'h0, 0, 3, 32'h1234_5000, 0));
        tbl.push_back(mk(LH, 10, 0, 32'h12, 0, 32'h8001_7FFF, 32'h10, 4'h0, 0, 10, 32'hFFFF_8001, 0));
        tbl.push_back(mk(LHU, 11, 0, 32'h10, 0, 32'h8001_F00D, 32'h10, 4'h0, 0, 11, 32'h0000_F00D, 0));
        tbl.push_back(mk(SB, 12, 0, 32'h41, 32'h1234_565A, 0, 32'h40, 4'h2, 32'h5A5A_5A5A, 0, 0, 0));
        tbl.push_back(mk(SW, 13, 0, 32'h80, 32'hDEAD_BEEF, 0, 32'h80, 4'hF, 32'hDEAD_BEEF, 0, 0, 0));
        tbl.push_back(mk(LW, 14, 0, 32'h40, 0, 32'hCAFE_F00D, 32'h40, 4'h0, 0, 14, 32'hCAFE_F00D, 0));
`ifdef ACCESSOR_MISALIGN_TRAP_EN
        tbl.push_back(mk(LW, 15, 0, 32'h101, 0, 32'h1111_2222, 32'h100, 4'h0, 0, 0, 0, 1));
        tbl.push_back(mk(SH, 16, 0, 32'h203, 32'h0000_7777, 0, 32'h200, 4'h0, 0, 0, 0, 1));
`else
        tbl.push_back(mk(LW, 15, 0, 32'h101, 0, 32'h1111_2222, 32'h100, 4'h0, 0, 15, 32'h1111_2222, 0));
        tbl.push_back(mk(SH, 16, 0, 32'h203, 32'h0000_7777, 0, 32'h200, 4'hC, 32'h7777_7777, 0, 0, 0));
        tbl.push_back(mk(LH, 17, 0, 32'h103, 0, 32'hF00D_0001, 32'h100, 4'h0, 0, 17, 32'hFFFF_F00D, 0));
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(accessor_ready), 32'd1);
        chk("rst_valid", 32'(accessor_valid), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_data", out_rd_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_mis", 32'(mis_o), 32'd0);
        reset = 0;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i], 0, 0);

        // Backpressure: bus stalls 5 cycles, writeback stalls 3
        run(tbl[1], 5, 3);
        run(tbl[3], 5, 3);
        run(tbl[0], 0, 3);

        // Async reset while the bus request is outstanding
        v = tbl[9];
        drive(v);
        executor_valid = 1;
        @(negedge clk);
        executor_valid = 0;
        chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
        #2 reset = 1;
        #1;
        chk("async_mem_valid", 32'(mem_valid), 32'd0);
        chk("async_valid", 32'(accessor_valid), 32'd0);
        chk("async_ready", 32'(accessor_ready), 32'd1);
        @(negedge clk);
        reset = 0;
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ready = 0;
        @(negedge clk);
        chk("late_ready_valid", 32'(accessor_valid), 32'd0);
        chk("late_ready_mem_valid", 32'(mem_valid), 32'd0);
        chk("late_ready_out_rd", 32'(out_rd), 32'd0);
        run(tbl[0], 1, 1);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            v.op    = op_e'($urandom_range(0, 9));
            v.rd    = 5'($urandom);
            v.rdd   = $urandom;
            v.addr  = $urandom;
            v.data  = $urandom;
            v.rdata = $urandom;
            v = model(v);
            run(v, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
